// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU operation scheduler: FSM encodings, ALU in_sel
// codes and default datapath widths.
package alu_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 7;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] WAIT = 2'b10;
  localparam logic [1:0] RESP = 2'b11;

  localparam logic [2:0] INSEL_PERSIST = 3'b100;
  localparam logic [2:0] INSEL_LOAD    = 3'b010;
  localparam logic [2:0] INSEL_RESET   = 3'b001;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first asserted request at or
// above rr_ptr, wrapping modulo NREQ. Pointer update is left to the caller.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic                    en,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         grant
);

  localparam int ID_W = $clog2(NREQ);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // rr_ptr < NREQ, so a single conditional subtract performs the wrap
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NREQ)) sum = sum - (ID_W+1)'(NREQ);
      idx = sum[ID_W-1:0];
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_sched.sv
// Schedules ops from NREQ requesters onto one shared ALU with round-robin
// arbitration. Optional illegal-op check enabled by defining ALU_OPCHK_EN.
module alu_op_sched
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int NREQ    = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ*OP_W-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     alu_on,
  output logic [2:0]               alu_in_sel,
  output logic [DATA_W-1:0]        alu_num1,
  output logic [DATA_W-1:0]        alu_num2,
  output logic [OP_W-1:0]          alu_out_sel,
  input  logic [DATA_W-1:0]        alu_out,
  output logic [1:0]               ctrl_state
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready is one-hot, only in IDLE, and does not depend on future valid;
  // rsp_valid/rsp_id/rsp_data/rsp_err stay stable until rsp_ready is seen.

  logic [1:0]        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   ptr_next;
  logic [NREQ-1:0]   grant;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              op_bad;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .en     (state == IDLE),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  assign req_ready  = grant;
  assign accept     = |grant;
  assign ctrl_state = state;

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gnt_id = ID_W'(i);
    end
  end

  assign sel_a    = req_a[gnt_id*DATA_W +: DATA_W];
  assign sel_b    = req_b[gnt_id*DATA_W +: DATA_W];
  assign sel_op   = req_op[gnt_id*OP_W +: OP_W];
  assign ptr_next = (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + 1'b1;

`ifdef ALU_OPCHK_EN
  assign op_bad = ($countones(sel_op) != 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       rsp_err <= 1'b0;
    else if (state == IDLE && accept) rsp_err <= op_bad;
  end
`else
  assign op_bad  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // ALU controls are registered alongside the next state, so they always
  // reflect the current state and drop to reset values asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      id_q        <= '0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      alu_on      <= 1'b0;
      alu_in_sel  <= INSEL_RESET;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_out_sel <= '0;
    end else begin
      alu_on <= 1'b1;
      case (state)
        IDLE: begin
          alu_in_sel  <= INSEL_PERSIST;
          alu_out_sel <= '0;
          if (accept) begin
            id_q   <= gnt_id;
            rr_ptr <= ptr_next;
            if (op_bad) begin
              rsp_valid <= 1'b1;
              rsp_id    <= gnt_id;
              rsp_data  <= '0;
              state     <= RESP;
            end else begin
              alu_in_sel  <= INSEL_LOAD;
              alu_num1    <= sel_a;
              alu_num2    <= sel_b;
              alu_out_sel <= sel_op;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          alu_in_sel <= INSEL_PERSIST;
          cnt        <= CNT_W'(ALU_LAT-1);
          state      <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= alu_out;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            alu_out_sel <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sched.sv
// Self-checking bench for alu_op_sched with a two-requester setup and a
// registered ALU stub; covers the ALU_OPCHK_EN build when that macro is set.
module tb_alu_op_sched;

  localparam logic ERR_ILL =
`ifdef ALU_OPCHK_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [13:0] req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        alu_on;
  logic [2:0]  alu_in_sel;
  logic [7:0]  alu_num1;
  logic [7:0]  alu_num2;
  logic [6:0]  alu_out_sel;
  logic [7:0]  alu_out;
  logic [1:0]  ctrl_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_ptr = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] op;
    logic [7:0] exp_d;
    logic       exp_e;
  } vec_t;
  vec_t vecs[8];

  alu_op_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_on(alu_on), .alu_in_sel(alu_in_sel),
    .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_sel(alu_out_sel), .alu_out(alu_out),
    .ctrl_state(ctrl_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ALU stub: result registered on the load edge, so ALU_LAT = 1
  function automatic logic [7:0] alu_stub(input logic [7:0] a, b, input logic [6:0] op);
    case (op)
      7'b1000000: return a + b;
      7'b0100000: return a - b;
      7'b0010000: return a & b;
      7'b0001000: return a | b;
      7'b0000100: return a ^ b;
      default:    return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_in_sel == 3'b001)      alu_out <= 8'h00;
    else if (alu_in_sel == 3'b010) alu_out <= alu_stub(alu_num1, alu_num2, alu_out_sel);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected {id, err, data} popped on each response handshake
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d data=%0h with nothing expected", rsp_id, rsp_data);
      end else begin
        chk("rsp", {22'd0, rsp_id, rsp_err, rsp_data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic send(input int id, input logic [7:0] a, b, input logic [6:0] op,
                      input logic [7:0] exp_d, input logic exp_e);
    bit got = 0;
    logic idb;
    idb = id[0];
    req_a[id*8 +: 8]  = a;
    req_b[id*8 +: 8]  = b;
    req_op[id*7 +: 7] = op;
    req_valid[id]     = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        exp_q.push_back({idb, exp_e, exp_d});
        exp_ptr = (id + 1) % 2;
        got = 1;
      end
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && ctrl_state == 2'b00) done = 1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int last;
    int gid;
    bit seen;

    vecs[0] = '{0, 8'h10, 8'h20, 7'b1000000, 8'h30, 1'b0};
    vecs[1] = '{1, 8'h50, 8'h08, 7'b0100000, 8'h48, 1'b0};
    vecs[2] = '{0, 8'hF0, 8'h3F, 7'b0010000, 8'h30, 1'b0};
    vecs[3] = '{1, 8'hA5, 8'h0F, 7'b0001000, 8'hAF, 1'b0};
    vecs[4] = '{0, 8'hFF, 8'h01, 7'b1000000, 8'h00, 1'b0};
    vecs[5] = '{1, 8'h00, 8'h01, 7'b0100000, 8'hFF, 1'b0};
    vecs[6] = '{0, 8'h3C, 8'hFF, 7'b0000100, 8'hC3, 1'b0};
    vecs[7] = '{1, 8'h12, 8'h34, 7'b1100000, 8'h00, ERR_ILL};

    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;

    // reset held with clock running
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_sel", alu_in_sel, 3'b001);
    chk("rst_alu_on", alu_on, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_state", ctrl_state, 2'b00);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_sel", alu_in_sel, 3'b100);
    chk("idle_alu_on", alu_on, 1);

    // single op, stepped through LOAD/WAIT/RESP
    send(0, 8'h57, 8'h1A, 7'b1000000, 8'h71, 1'b0);
    chk("load_state", ctrl_state, 2'b01);
    chk("load_in_sel", alu_in_sel, 3'b010);
    chk("load_num1", alu_num1, 8'h57);
    chk("load_num2", alu_num2, 8'h1A);
    chk("load_op", alu_out_sel, 7'b1000000);
    chk("ready_pulse", req_ready, 0);
    @(posedge clk); #1;
    chk("wait_state", ctrl_state, 2'b10);
    chk("wait_in_sel", alu_in_sel, 3'b100);
    chk("wait_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_data", rsp_data, 8'h71);
    chk("resp_id", rsp_id, 0);
    drain();

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_d, vecs[i].exp_e);
      drain();
    end

    // contention: both held valid, grants alternate at ALU_LAT+3 spacing
    req_a = {8'h07, 8'h57}; req_b = {8'h02, 8'h1A}; req_op = {7'b0100000, 7'b1000000};
    req_valid = 2'b11;
    n = 0; last = 0;
    for (int k = 0; k < 100 && n < 4; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        chk("ready_onehot", $countones(req_ready), 1);
        gid = req_ready[1] ? 1 : 0;
        chk("rr_grant", gid, exp_ptr);
        if (n > 0) chk("rr_spacing", cyc - last, 4);
        last = cyc;
        exp_q.push_back({gid[0], 1'b0, (gid == 1) ? 8'h05 : 8'h71});
        exp_ptr = 1 - gid;
        n++;
      end
    end
    if (n < 4) chk("contention_timeout", n, 4);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // backpressure with a pending request from requester 1
    rsp_ready = 1'b0;
    send(0, 8'h57, 8'h1A, 7'b1000000, 8'h71, 1'b0);
    req_valid[1] = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1;
    end
    if (!seen) chk("bp_rsp_timeout", 0, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 8'h71);
      chk("bp_id", rsp_id, 0);
      chk("bp_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", ctrl_state, 2'b00);
    chk("bp_pending_grant", req_ready, 2'b10);
    if (req_ready[1]) exp_q.push_back({1'b1, 1'b0, 8'h05});
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("bp_load", ctrl_state, 2'b01);
    drain();

    // abort in WAIT
    send(1, 8'h07, 8'h02, 7'b0100000, 8'h05, 1'b0);
    @(posedge clk); #1;
    chk("abort_in_wait", ctrl_state, 2'b10);
    rst = 1'b0;
    #1;
    chk("abort_state", ctrl_state, 2'b00);
    chk("abort_in_sel", alu_in_sel, 3'b001);
    chk("abort_alu_on", alu_on, 0);
    chk("abort_num1", alu_num1, 0);
    chk("abort_out_sel", alu_out_sel, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_ptr = 0;
    req_a = {8'h07, 8'h57}; req_b = {8'h02, 8'h1A}; req_op = {7'b0100000, 7'b1000000};
    req_valid = 2'b11;
    @(negedge clk);
    chk("abort_first_grant", req_ready, 2'b01);
    if (req_ready == 2'b01) exp_q.push_back({1'b0, 1'b0, 8'h71});
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // illegal (non-one-hot) op
`ifdef ALU_OPCHK_EN
    send(0, 8'h12, 8'h34, 7'b1100000, 8'h00, 1'b1);
    chk("ill_state", ctrl_state, 2'b11);
    chk("ill_valid", rsp_valid, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_data", rsp_data, 0);
    chk("ill_in_sel", alu_in_sel, 3'b100);
`else
    send(0, 8'h12, 8'h34, 7'b1100000, 8'h00, 1'b0);
    chk("ill_state", ctrl_state, 2'b01);
    chk("ill_verbatim", alu_out_sel, 7'b1100000);
    chk("ill_err", rsp_err, 0);
`endif
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
